mem_port_arbiter: RTL and testbench

- Shares the single memory bus port between the instruction-fetch requester and the memory-stage requester (load/store).
- Inputs are the stage sequencer's one-cycle start_fetch / start_memory pulses.
- Holds `blocked` high back to the sequencer until the bus access completes.
- Sits between the stage counter, the fetch/memory stages and the external memory bus.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_req_latch.sv | 34 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// requester IDs (also used as indices into the per-requester arrays).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_MEM   = 1'b1;
  localparam int   NUM_REQ   = 2;

endpackage

// File: rtl/mem_req_latch.sv
// One requester's capture slot: pending flag, operand register and
// duplicate-request detection. A pulse while the slot is busy is dropped
// (operands kept) and reported on overlap for that cycle.
module mem_req_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] ops,
  input  logic         clear,
  output logic         pending,
  output logic [W-1:0] ops_q,
  output logic         overlap
);

  // Busy covers both waiting and in-flight, since pending only clears at
  // completion of the bus access.
  assign overlap = start & pending;

  // Pending flag and operand capture; completion clears the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      ops_q   <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (start && !pending) begin
      pending <= 1'b1;
      ops_q   <= ops;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus port between instruction fetch and the
// load/store stage. Memory stage wins ties (older instruction). Holds
// blocked to the stage sequencer while any access is outstanding.
// Optional bus timeout abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_fetch,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic [DATA_W-1:0]   fetch_data,
  output logic                fetch_valid,
  input  logic                start_memory,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_done,
  output logic                bus_req,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                blocked,
  output logic                err_overlap,
  output logic                err_timeout
);

  localparam int SW  = DATA_W / 8;
  // Operand bundle layout: {addr, wdata, wstrb, we}
  localparam int OPW = ADDR_W + DATA_W + SW + 1;

  arb_state_e                     state;
  logic                           sel;
  logic [NUM_REQ-1:0]             start, want, pend, clr, ovl;
  logic [NUM_REQ-1:0][OPW-1:0]    ops_in, ops_q, ops_eff;
  logic                           nxt_sel;
  logic [OPW-1:0]                 nxt_ops;
  logic                           to_hit;
  logic                           bus_end;

  assign start[REQ_FETCH]  = start_fetch;
  assign start[REQ_MEM]    = start_memory;
  assign ops_in[REQ_FETCH] = {fetch_addr, {(OPW-ADDR_W){1'b0}}};
  assign ops_in[REQ_MEM]   = {mem_addr, mem_wdata, mem_wstrb, mem_we};

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_req
    mem_req_latch #(.W(OPW)) u_latch (
      .clk     (clk),
      .rst     (rst),
      .start   (start[g]),
      .ops     (ops_in[g]),
      .clear   (clr[g]),
      .pending (pend[g]),
      .ops_q   (ops_q[g]),
      .overlap (ovl[g])
    );
    // A request pulsing this cycle is served straight from the input so
    // bus_req can rise on the very next cycle.
    assign ops_eff[g] = pend[g] ? ops_q[g] : ops_in[g];
    assign clr[g]     = bus_end & (sel == 1'(g));
  end

  assign want    = pend | start;
  assign nxt_sel = want[REQ_MEM] ? REQ_MEM : REQ_FETCH;
  assign nxt_ops = ops_eff[nxt_sel];
  assign bus_end = (state == ARB_BUS) & (bus_ack | to_hit);
  assign blocked = (|start) | (|pend) | (state == ARB_BUS);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Fires on the edge that would complete TIMEOUT_CYCLES unacked BUS cycles.
  assign to_hit = !bus_ack && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Unacked-cycle counter; held at zero outside BUS so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst || state != ARB_BUS) to_cnt <= '0;
    else if (!bus_ack)           to_cnt <= to_cnt + 1'b1;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst)                            err_timeout <= 1'b0;
    else if (state == ARB_BUS && to_hit) err_timeout <= 1'b1;
  end
`else
  // No abort path in this build; BUS waits for bus_ack indefinitely.
  assign to_hit      = (TIMEOUT_CYCLES < 0);
  assign err_timeout = 1'b0;
`endif

  // Arbitration FSM with registered bus outputs, results and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      sel         <= REQ_FETCH;
      bus_req     <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      bus_we      <= 1'b0;
      fetch_data  <= '0;
      mem_rdata   <= '0;
      fetch_valid <= 1'b0;
      mem_done    <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      mem_done    <= 1'b0;
      if (|ovl) err_overlap <= 1'b1;
      case (state)
        ARB_IDLE, ARB_DONE: begin
          if (|want) begin
            state   <= ARB_BUS;
            sel     <= nxt_sel;
            bus_req <= 1'b1;
            {bus_addr, bus_wdata, bus_wstrb, bus_we} <= nxt_ops;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_BUS: begin
          if (bus_end) begin
            bus_req <= 1'b0;
            state   <= ARB_DONE;
            // An aborted access returns zero as its result.
            if (sel == REQ_MEM) begin
              mem_done <= 1'b1;
              if (!bus_we) mem_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              fetch_valid <= 1'b1;
              fetch_data  <= bus_ack ? bus_rdata : '0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_fetch, start_memory, mem_we, bus_ack;
  logic [31:0] fetch_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] fetch_data, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        fetch_valid, mem_done, bus_req, bus_we, blocked;
  logic        err_overlap, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .start_fetch(start_fetch), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .start_memory(start_memory), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .blocked(blocked), .err_overlap(err_overlap), .err_timeout(err_timeout)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start_fetch = 0; start_memory = 0; bus_ack = 0; mem_we = 0;
    fetch_addr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus_req, fetch_valid, mem_done, err_overlap, err_timeout, bus_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000000",
        {bus_req, fetch_valid, mem_done, err_overlap, err_timeout, bus_we});
    end
    n_checks++;
    if ({fetch_data, mem_rdata, bus_addr, bus_wdata, bus_wstrb} !== 132'b0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0",
        fetch_data, mem_rdata, bus_addr, bus_wdata, bus_wstrb);
    end
    n_checks++;
    if (blocked !== 1'b0) begin n_fail++; $display("FAIL reset_blocked got=%b exp=0", blocked); end
  endtask

  task automatic test_fetch_only();
    do_reset();
    start_fetch = 1; fetch_addr = 32'h100; #1;
    n_checks++;
    if (blocked !== 1'b1) begin n_fail++; $display("FAIL fo_blocked_c0 got=%b exp=1", blocked); end
    step(); start_fetch = 0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0) begin
        n_fail++; $display("FAIL fo_bus_c%0d got req=%b addr=%h we=%b exp req=1 addr=100 we=0",
          c, bus_req, bus_addr, bus_we);
      end
      if (c == 3) begin bus_ack = 1; bus_rdata = 32'hDEADBEEF; end
      else step();
    end
    step(); bus_ack = 0; bus_rdata = 0; #1;
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_data !== 32'hDEADBEEF || bus_req !== 1'b0 || blocked !== 1'b0) begin
      n_fail++; $display("FAIL fo_done_c4 got fv=%b fd=%h req=%b blk=%b exp fv=1 fd=deadbeef req=0 blk=0",
        fetch_valid, fetch_data, bus_req, blocked);
    end
    step();
    n_checks++;
    if (fetch_valid !== 1'b0 || mem_done !== 1'b0) begin
      n_fail++; $display("FAIL fo_pulse_c5 got fv=%b md=%b exp 0 0", fetch_valid, mem_done);
    end
  endtask

  task automatic test_store();
    do_reset();
    start_memory = 1; mem_addr = 32'h200; mem_wdata = 32'h12345678; mem_we = 1; mem_wstrb = 4'hF;
    step(); start_memory = 0; mem_addr = 0; mem_wdata = 0; mem_we = 0; mem_wstrb = 0;
    for (int c = 1; c <= 2; c++) begin
      n_checks++;
      if (bus_req !== 1 || bus_addr !== 32'h200 || bus_wdata !== 32'h12345678 || bus_we !== 1 || bus_wstrb !== 4'hF) begin
        n_fail++; $display("FAIL st_bus_c%0d got req=%b a=%h d=%h we=%b s=%h exp 1 200 12345678 1 f",
          c, bus_req, bus_addr, bus_wdata, bus_we, bus_wstrb);
      end
      if (c == 1) step();
    end
    bus_ack = 1; bus_rdata = 32'hAAAA5555;
    step(); bus_ack = 0;
    n_checks++;
    if (mem_done !== 1 || fetch_valid !== 0 || mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL st_done got md=%b fv=%b rd=%h exp md=1 fv=0 rd=0", mem_done, fetch_valid, mem_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_fetch = 1; fetch_addr = 32'h104; start_memory = 1; mem_addr = 32'h300; mem_we = 0;
    step(); start_fetch = 0; start_memory = 0;
    n_checks++;
    if (bus_req !== 1 || bus_addr !== 32'h300 || blocked !== 1) begin
      n_fail++; $display("FAIL sim_first got req=%b a=%h blk=%b exp 1 300 1", bus_req, bus_addr, blocked);
    end
    bus_ack = 1; bus_rdata = 32'h11;
    step(); bus_ack = 0;
    n_checks++;
    if (mem_done !== 1 || fetch_valid !== 0 || mem_rdata !== 32'h11 || bus_req !== 0 || blocked !== 1) begin
      n_fail++; $display("FAIL sim_mdone got md=%b fv=%b rd=%h req=%b blk=%b exp 1 0 11 0 1",
        mem_done, fetch_valid, mem_rdata, bus_req, blocked);
    end
    step();
    n_checks++;
    if (bus_req !== 1 || bus_addr !== 32'h104 || mem_done !== 0 || blocked !== 1) begin
      n_fail++; $display("FAIL sim_second got req=%b a=%h md=%b blk=%b exp 1 104 0 1", bus_req, bus_addr, mem_done, blocked);
    end
    bus_ack = 1; bus_rdata = 32'h22;
    step(); bus_ack = 0;
    n_checks++;
    if (fetch_valid !== 1 || fetch_data !== 32'h22 || blocked !== 0) begin
      n_fail++; $display("FAIL sim_fdone got fv=%b fd=%h blk=%b exp 1 22 0", fetch_valid, fetch_data, blocked);
    end
  endtask

  task automatic test_duplicate();
    int nv;
    do_reset();
    start_fetch = 1; fetch_addr = 32'h100;
    step(); start_fetch = 1; fetch_addr = 32'h999;
    step(); start_fetch = 0;
    n_checks++;
    if (err_overlap !== 1 || bus_addr !== 32'h100) begin
      n_fail++; $display("FAIL dup_ovl got ovl=%b a=%h exp 1 100", err_overlap, bus_addr);
    end
    bus_ack = 1; bus_rdata = 32'h77;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      step(); bus_ack = 0;
      if (fetch_valid === 1'b1) nv++;
    end
    n_checks++;
    if (nv !== 1 || bus_req !== 0 || err_overlap !== 1) begin
      n_fail++; $display("FAIL dup_count got fv_pulses=%0d req=%b ovl=%b exp 1 0 1", nv, bus_req, err_overlap);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_fetch = 1; fetch_addr = 32'h140;
    step(); start_fetch = 0;
    step(); rst = 1;
    step(); rst = 0;
    n_checks++;
    if (bus_req !== 0) begin n_fail++; $display("FAIL rm_req got=%b exp=0", bus_req); end
    bus_ack = 1; bus_rdata = 32'h5A5A;
    step(); bus_ack = 0;
    n_checks++;
    if (fetch_valid !== 0 || mem_done !== 0 || bus_req !== 0 || blocked !== 0 || err_overlap !== 0 || err_timeout !== 0 || fetch_data !== 0) begin
      n_fail++; $display("FAIL rm_after got fv=%b md=%b req=%b blk=%b ovl=%b to=%b fd=%h exp all 0",
        fetch_valid, mem_done, bus_req, blocked, err_overlap, err_timeout, fetch_data);
    end
    step();
    n_checks++;
    if (fetch_valid !== 0 || bus_req !== 0) begin
      n_fail++; $display("FAIL rm_late got fv=%b req=%b exp 0 0", fetch_valid, bus_req);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_fetch = 1; fetch_addr = 32'h10;
    step(); start_fetch = 0; bus_ack = 1; bus_rdata = 32'h55;
    step(); bus_ack = 0; step();
    start_fetch = 1; fetch_addr = 32'h20;
    step(); start_fetch = 0;
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (bus_req !== 1) begin n_fail++; $display("FAIL to_req_c%0d got=%b exp=1", c, bus_req); end
      step();
    end
    n_checks++;
    if (bus_req !== 0 || fetch_valid !== 1 || fetch_data !== 0 || err_timeout !== 1) begin
      n_fail++; $display("FAIL to_abort got req=%b fv=%b fd=%h to=%b exp 0 1 0 1", bus_req, fetch_valid, fetch_data, err_timeout);
    end
    step(); step();
    n_checks++;
    if (err_timeout !== 1) begin n_fail++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
  endtask
`endif

  // Transaction-level model: each requester has at most one outstanding
  // access; a new access starts the cycle after any is outstanding and the
  // bus is free (memory first); completion is announced the cycle after ack.
  task automatic test_random();
    bit out_f, out_m, in_fl, ack_prev, sel_m, m_we, exp_ovl, done_f, done_m, exp_req, pre_blk;
    bit sf, sm;
    logic [31:0] fa, ma, mw, ack_data, exp_fd, exp_mr;
    logic [3:0]  ms;
    int wt;
    do_reset();
    out_f = 0; out_m = 0; in_fl = 0; ack_prev = 0; sel_m = 0; m_we = 0; exp_ovl = 0;
    fa = 0; ma = 0; mw = 0; ms = 0; ack_data = 0; exp_fd = 0; exp_mr = 0; wt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      done_f = 0; done_m = 0;
      if (ack_prev) begin
        in_fl = 0;
        if (sel_m) begin done_m = 1; out_m = 0; if (!m_we) exp_mr = ack_data; end
        else begin done_f = 1; out_f = 0; exp_fd = ack_data; end
      end
      if (ack_prev)            exp_req = 0;
      else if (in_fl)          exp_req = 1;
      else if (out_f || out_m) begin exp_req = 1; in_fl = 1; sel_m = out_m; wt = $urandom_range(0, 3); end
      else                     exp_req = 0;
      ack_prev = 0;

      n_checks++;
      if (bus_req !== exp_req || fetch_valid !== done_f || mem_done !== done_m) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got req=%b fv=%b md=%b exp %b %b %b",
          cyc, bus_req, fetch_valid, mem_done, exp_req, done_f, done_m);
      end
      if (done_f) begin
        n_checks++;
        if (fetch_data !== exp_fd) begin n_fail++; $display("FAIL rnd_fdata cyc=%0d got=%h exp=%h", cyc, fetch_data, exp_fd); end
      end
      if (done_m) begin
        n_checks++;
        if (mem_rdata !== exp_mr) begin n_fail++; $display("FAIL rnd_mdata cyc=%0d got=%h exp=%h", cyc, mem_rdata, exp_mr); end
      end
      if (in_fl) begin
        n_checks++;
        if (bus_addr !== (sel_m ? ma : fa) || bus_we !== (sel_m & m_we) ||
            (sel_m && m_we && (bus_wdata !== mw || bus_wstrb !== ms))) begin
          n_fail++; $display("FAIL rnd_bus cyc=%0d got a=%h we=%b d=%h s=%h exp a=%h we=%b d=%h s=%h",
            cyc, bus_addr, bus_we, bus_wdata, bus_wstrb, sel_m ? ma : fa, sel_m & m_we, mw, ms);
        end
      end
      n_checks++;
      if (err_overlap !== exp_ovl) begin n_fail++; $display("FAIL rnd_ovl cyc=%0d got=%b exp=%b", cyc, err_overlap, exp_ovl); end

      pre_blk = out_f | out_m | in_fl;
      sf = ($urandom_range(0, 3) == 0);
      sm = ($urandom_range(0, 3) == 0);
      start_fetch = sf; fetch_addr = $urandom;
      start_memory = sm; mem_addr = $urandom; mem_wdata = $urandom;
      mem_we = $urandom_range(0, 1); mem_wstrb = 4'($urandom);
      if (sf) begin if (out_f) exp_ovl = 1; else begin out_f = 1; fa = fetch_addr; end end
      if (sm) begin
        if (out_m) exp_ovl = 1;
        else begin out_m = 1; ma = mem_addr; mw = mem_wdata; m_we = mem_we; ms = mem_wstrb; end
      end
      bus_rdata = $urandom;
      bus_ack = 0;
      if (in_fl) begin
        if (wt == 0) begin bus_ack = 1; ack_data = bus_rdata; ack_prev = 1; end
        else wt--;
      end else begin
        bus_ack = ($urandom_range(0, 7) == 0);
      end
      #1;
      n_checks++;
      if (blocked !== (pre_blk | sf | sm)) begin
        n_fail++; $display("FAIL rnd_blocked cyc=%0d got=%b exp=%b", cyc, blocked, pre_blk | sf | sm);
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_fetch_only();
    test_store();
    test_simultaneous();
    test_duplicate();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
